// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage of the multi-cycle CPU.
// Owns the PC, presents it to the instruction memory, captures the returned
// word into IR and hands it to the control unit, which later commits the next
// PC (sequential, branch, jump or register) with a one-cycle PCWrite strobe.
// A fetched word whose opcode equals HALT_OP stops fetching until reset.
// Optional macro IFETCH_BOUND_CHECK_EN: adds an address check in FETCH
// (misaligned PC or PC past the last memory word) that parks the unit in a
// FAULT state and raises Fault. Without it, Fault is constant 0.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 701,
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Run,
  output logic [31:0] IAddr,
  output logic        IRW,
  input  logic [31:0] IDataIn,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        IRValid,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] RegData,
  output logic        Halted,
  output logic        Fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
`ifdef IFETCH_BOUND_CHECK_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic        irvalid_reg;
  logic        halted_reg;
  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] pc_next;
  logic        fetch_bad;

  assign pc4     = pc_reg + 32'd4;
  assign IAddr   = pc_reg;
  assign IRW     = 1'b0;
  assign PC      = pc_reg;
  assign PC4     = pc4;
  assign IR      = ir_reg;
  assign IRValid = irvalid_reg;
  assign Halted  = halted_reg;

  // Next-PC candidate chosen by PCSrc; only consumed when PCWrite commits in HOLD.
  always_comb begin
    branch_off = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
    case (PCSrc)
      2'd0:    pc_next = pc4;
      2'd1:    pc_next = pc4 + branch_off;
      2'd2:    pc_next = {pc4[31:28], ir_reg[25:0], 2'b00};
      default: pc_next = RegData;
    endcase
  end

`ifdef IFETCH_BOUND_CHECK_EN
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES) - 32'd4;

  logic fault_reg;

  // A fetch is illegal when the PC is not word aligned or the word would
  // extend past the end of the instruction memory.
  assign fetch_bad = (pc_reg[1:0] != 2'b00) || (pc_reg > LAST_ADDR);
  assign Fault     = fault_reg;
`else
  assign fetch_bad = 1'b0;
  assign Fault     = 1'b0;

  // The memory size only feeds the bound check; a memory smaller than one
  // word is meaningless in either build.
  if (MEM_BYTES < 4) begin : g_mem_too_small
  end
`endif

  // Fetch FSM: state, PC, IR and all status flags move together on the clock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'h0;
      irvalid_reg <= 1'b0;
      halted_reg  <= 1'b0;
`ifdef IFETCH_BOUND_CHECK_EN
      fault_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Run) begin
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_bad) begin
`ifdef IFETCH_BOUND_CHECK_EN
            state_reg <= S_FAULT;
            fault_reg <= 1'b1;
`endif
          end else if (Run) begin
            ir_reg <= IDataIn;
            if (IDataIn[31:26] == HALT_OP) begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg   <= S_HOLD;
              irvalid_reg <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (PCWrite) begin
            pc_reg      <= pc_next;
            irvalid_reg <= 1'b0;
            state_reg   <= S_FETCH;
          end
        end
        S_HALT: begin
          // Terminal until reset; PC and IR keep the halt instruction.
        end
`ifdef IFETCH_BOUND_CHECK_EN
        S_FAULT: begin
          // Terminal until reset; IR keeps the last good instruction.
        end
`endif
        default: begin
          state_reg   <= S_IDLE;
          irvalid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage of the multi-cycle CPU; sits directly upstream of the byte-addressed instruction memory and downstream of nothing but the control unit.
- Owns the PC, drives the memory address, latches the returned word into the instruction register (IR), and computes the next PC from control-unit selection.
- Provides a one-instruction handshake to the control unit and stops on the halt opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 701, instruction memory size in bytes, used by the bound check.
- HALT_OP, 6'b111111, opcode in IR[31:26] that halts fetching.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- Run  input  1  fetch enable; sampled in IDLE and FETCH.
- IAddr  output  32  byte address to instruction memory; equals PC.
- IRW  output  1  memory read/write select; tied to 0 (read only).
- IDataIn  input  32  instruction word returned combinationally by memory.
- IR  output  32  latched instruction register.
- PC  output  32  address of the instruction held in IR.
- PC4  output  32  PC + 4, for jal link.
- IRValid  output  1  IR holds an instruction awaiting PC update.
- PCWrite  input  1  one-cycle strobe from control unit: commit next PC.
- PCSrc  input  2  next-PC select: 0 = PC4, 1 = branch, 2 = jump, 3 = register.
- RegData  input  32  register value for jr (PCSrc = 3).
- Halted  output  1  halt opcode was fetched.
- Fault  output  1  fetch address error (macro only; 0 otherwise).

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset values:
  - PC = RESET_PC, IR = 0, IRValid = 0, Halted = 0, Fault = 0, state = IDLE.
  - RST overrides every other input in every state, including mid-handshake and HALT.
- States:
  - IDLE: IRValid = 0. If Run = 1, go to FETCH next cycle.
  - FETCH: IAddr = PC. If Run = 1, at the edge IR <= IDataIn and state goes to HOLD; if that word's opcode equals HALT_OP, state goes to HALT instead. If Run = 0, stay in FETCH and leave IR unchanged.
  - HOLD: IRValid = 1; IR and PC are stable. On PCWrite = 1, PC <= next PC, IRValid drops, and state goes to FETCH. Run is ignored in HOLD.
  - HALT: Halted = 1, IRValid = 0. PC and IR keep the halt instruction. Only RST exits.
  - FAULT (macro only): Fault = 1, IRValid = 0. Only RST exits.
- Fetch latency: 2 cycles per instruction minimum (FETCH to HOLD, then PCWrite in HOLD), plus any control-unit wait.
- Next-PC arithmetic (32-bit, wrap-around modulo 2^32, no overflow flag):
  - seq = PC + 4.
  - branch = PC + 4 + (sign-extend(IR[15:0]) << 2).
  - jump = {PC4[31:28], IR[25:0], 2'b00}.
  - reg = RegData, unmodified.
- PCWrite outside HOLD is ignored; PC is unchanged.
- PCSrc is sampled only on the cycle PCWrite = 1.
- IAddr = PC in every state; IRW = 0 always.

Optional Feature:
- Macro: IFETCH_BOUND_CHECK_EN.
- With the macro:
  - In FETCH, if PC[1:0] != 0 or PC > MEM_BYTES - 4, IR is not loaded and state goes to FAULT with Fault = 1.
  - The check is evaluated in FETCH regardless of Run.
  - The check takes priority over the halt-opcode test.
- Without the macro: no check is made, the Fault output is constant 0, and the FAULT state does not exist.

Test Plan:
- Hold RST for 2 cycles with Run = 1 -> PC = 0, IR = 0, IRValid = 0, Halted = 0. Release -> IDLE, then FETCH, then HOLD with IRValid = 1.
- Memory at 0 holds 32'hE0000002 (j). In HOLD, PCWrite = 1, PCSrc = 2 -> PC = 8; next fetch IAddr = 8.
- PC = 44, IR = 32'hD024FFFD. PCWrite with PCSrc = 1 -> PC = 36. Same instruction with PCSrc = 0 -> PC = 48.
- PC = 136, IR = jr, RegData = 16, PCSrc = 3 -> PC = 16. Check PC4 = 140 while in HOLD.
- Memory word 32'hFF026200 at PC = 48 -> Halted = 1, IRValid = 0. PCWrite pulses then leave PC at 48. RST -> PC = 0, Halted = 0.
- PCWrite pulsed during FETCH and IDLE -> PC unchanged. With IFETCH_BOUND_CHECK_EN, jr to RegData = 6 -> Fault = 1 on the next cycle and IR keeps its prior value. Jr to 700 -> Fault = 1.
